spi_conf_receiver: RTL

SPI_CONF_RECEIVER -- requirements
Module: spi_conf_receiver

---
 rtl/spi_conf_receiver_pkg.sv | 39 +++
 rtl/spi_conf_receiver_if.sv | 25 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/spi_conf_receiver.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/spi_conf_receiver_pkg.sv
// Shared FPGA constants for the SPI configuration receiver: command codes,
// word geometry, reset values, major-mode encodings and FSM state type.
package spi_conf_receiver_pkg;

    localparam int unsigned WordWidth = 16;
    localparam int unsigned CntWidth  = 5;

    localparam logic [3:0] CmdSetMajorMode = 4'h1;
    localparam logic [3:0] CmdSetDivisor   = 4'h2;

    localparam logic [7:0]          DivisorReset = 8'd95;
    localparam logic [CntWidth-1:0] FullCount    = 5'd16;
    // One past a full word, so over-long frames never look like 16 bits.
    localparam logic [CntWidth-1:0] CntSat       = 5'd17;

    typedef enum logic [2:0] {
        MmLfReader     = 3'd0,
        MmLfEdgeDetect = 3'd1,
        MmHfReader     = 3'd2,
        MmHfSimulator  = 3'd3,
        MmHfIso14443a  = 3'd4,
        MmLfPassthru   = 3'd5,
        MmHfFsk        = 3'd6,
        MmOff          = 3'd7
    } major_mode_e;

    localparam major_mode_e MajorModeReset = MmLfReader;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StCheck = 2'd2
    } state_e;

    function automatic logic [3:0] cmd_of(input logic [WordWidth-1:0] word);
        return word[WordWidth-1 -: 4];
    endfunction

endpackage

// File: rtl/spi_conf_receiver_if.sv
// SPI pins from the ARM plus the decoded configuration outputs.
interface spi_conf_receiver_if;
    import spi_conf_receiver_pkg::*;

    logic                 spcki;
    logic                 mosi;
    logic                 ncs;
    logic [WordWidth-1:0] conf_word;
    logic [2:0]           major_mode;
    logic [7:0]           divisor;
    logic                 conf_strobe;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output spcki, mosi, ncs,
        input  conf_word, major_mode, divisor, conf_strobe, frame_err, busy
    );

    modport slave (
        input  spcki, mosi, ncs,
        output conf_word, major_mode, divisor, conf_strobe, frame_err, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
module sync_2ff #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Resolve metastability over two stages; reset to the pin's idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= ResetVal;
            q      <= ResetVal;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/spi_conf_receiver.sv
// Receives 16-bit configuration words over SPI from the ARM, validates the
// frame length and decodes major-mode / divisor commands.
module spi_conf_receiver
    import spi_conf_receiver_pkg::*;
(
    input logic                ck_1356meg,
    input logic                rst,
    spi_conf_receiver_if.slave bus
);

    logic spcki_s, mosi_s, ncs_s;
    logic spcki_q, ncs_q;
    logic spcki_rise, ncs_rise, ncs_fall;

    logic [1:0] flush_q;
    logic       armed_q;

    state_e               state_q;
    logic [CntWidth-1:0]  bit_cnt_q;
    logic [WordWidth-1:0] shreg_q;
    logic [WordWidth-1:0] conf_word_q;
    logic [2:0]           major_mode_q;
    logic [7:0]           divisor_q;
    logic                 conf_strobe_q;
    logic                 frame_err_q;
    logic                 busy_q;

    sync_2ff #(.ResetVal(1'b0)) u_sync_spcki (
        .clk (ck_1356meg),
        .rst (rst),
        .d   (bus.spcki),
        .q   (spcki_s)
    );

    sync_2ff #(.ResetVal(1'b0)) u_sync_mosi (
        .clk (ck_1356meg),
        .rst (rst),
        .d   (bus.mosi),
        .q   (mosi_s)
    );

    sync_2ff #(.ResetVal(1'b1)) u_sync_ncs (
        .clk (ck_1356meg),
        .rst (rst),
        .d   (bus.ncs),
        .q   (ncs_s)
    );

    // Third copy of the synced clock and select for edge detection.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            spcki_q <= 1'b0;
            ncs_q   <= 1'b1;
        end else begin
            spcki_q <= spcki_s;
            ncs_q   <= ncs_s;
        end
    end

    assign spcki_rise = spcki_s & ~spcki_q;
    assign ncs_rise   = ncs_s & ~ncs_q;
    assign ncs_fall   = ~ncs_s & ncs_q;

    // Arm frame start only once ncs has been seen high after the sync
    // pipeline has flushed its reset values, so a select already low at
    // reset release cannot open a frame.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            flush_q <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (flush_q != 2'd3) begin
                flush_q <= flush_q + 2'd1;
            end
            if (flush_q == 2'd3 && ncs_s && ncs_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Frame FSM with registered outputs: shift, then validate and commit.
    always_ff @(posedge ck_1356meg or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            conf_word_q   <= '0;
            major_mode_q  <= MajorModeReset;
            divisor_q     <= DivisorReset;
            conf_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            conf_strobe_q <= 1'b0;
            frame_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ncs_fall && armed_q) begin
                        state_q   <= StShift;
                        bit_cnt_q <= '0;
                        shreg_q   <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StShift: begin
                    if (spcki_rise) begin
                        shreg_q <= {shreg_q[WordWidth-2:0], mosi_s};
                        if (bit_cnt_q != CntSat) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                        end
                    end
                    if (ncs_rise) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (bit_cnt_q == FullCount) begin
                        conf_word_q   <= shreg_q;
                        conf_strobe_q <= 1'b1;
                        case (cmd_of(shreg_q))
                            CmdSetMajorMode: major_mode_q <= shreg_q[2:0];
                            CmdSetDivisor:   divisor_q    <= shreg_q[7:0];
                            default: ;
                        endcase
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.conf_word   = conf_word_q;
    assign bus.major_mode  = major_mode_q;
    assign bus.divisor     = divisor_q;
    assign bus.conf_strobe = conf_strobe_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;

endmodule
